// File: rtl/sync_fifo_param.sv
// sync_fifo_param
//   Single-clock synchronous FIFO with chip select, occupancy count,
//   programmable almost-full / almost-empty flags and one-cycle
//   overflow / underflow error pulses.
//
//   Optional feature macro: SYNC_FIFO_FWFT_EN
//     defined   -> first-word-fall-through: data_out shows mem[rd_ptr]
//                  whenever the FIFO is not empty, rd_en pops the head.
//     undefined -> standard mode: data_out is a register loaded on the
//                  edge where a read is accepted (1-cycle latency).
//
//   Ports
//     clk          rising-edge clock
//     rst          asynchronous active-high reset
//     cs           chip select; gates wr_en and rd_en
//     wr_en        write request
//     rd_en        read request / pop acknowledge (FWFT)
//     data_in      write data, WIDTH bits
//     data_out     read data, WIDTH bits
//     empty        count == 0
//     full         count == DEPTH
//     almost_full  count >= AFULL_THRESH
//     almost_empty count <= AEMPTY_THRESH
//     count        occupancy 0..DEPTH
//     overflow     registered pulse: write requested while full
//     underflow    registered pulse: read requested while empty
//
//   Handshake: a write is taken on any rising edge where cs & wr_en & !full,
//   a read where cs & rd_en & !empty; both use the flags as they were
//   before the edge, so a request against a full/empty FIFO is dropped and
//   reported on overflow/underflow after that edge.
module sync_fifo_param #(
    parameter int WIDTH         = 32,
    parameter int DEPTH         = 128,
    parameter int AFULL_THRESH  = DEPTH - 4,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cs,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic [WIDTH-1:0]         data_in,
    output logic [WIDTH-1:0]         data_out,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    localparam logic [PW-1:0] AF_T = PW'(AFULL_THRESH);
    localparam logic [PW-1:0] AE_T = PW'(AEMPTY_THRESH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic          wr_acc;
    logic          rd_acc;

    assign wr_addr = wr_ptr_q[AW-1:0];
    assign rd_addr = rd_ptr_q[AW-1:0];

    // Flags decode straight from the registered pointers and count.
    assign empty        = (wr_ptr_q == rd_ptr_q);
    assign full         = (wr_addr == rd_addr) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign almost_full  = (count_q >= AF_T);
    assign almost_empty = (count_q <= AE_T);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Acceptance uses pre-edge flags: at full only the read can go, at
    // empty only the write can go.
    assign wr_acc = cs & wr_en & ~full;
    assign rd_acc = cs & rd_en & ~empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = cs & wr_en & full;
        underflow_d = cs & rd_en & empty;
        if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
        if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + PW'(1);
            2'b01:   count_d = count_q - PW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_addr] <= data_in;
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head entry is always presented; meaningless while empty.
    assign data_out = mem[rd_addr];
`else
    logic [WIDTH-1:0] data_out_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         data_out_q <= '0;
        else if (rd_acc) data_out_q <= mem[rd_addr];
    end

    assign data_out = data_out_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param with DEPTH=8, AFULL=6, AEMPTY=2.
module tb_sync_fifo_param;

  localparam int W  = 16;
  localparam int D  = 8;
  localparam int AF = 6;
  localparam int AE = 2;

  logic          clk;
  logic          rst;
  logic          cs;
  logic          wr_en;
  logic          rd_en;
  logic [W-1:0]  data_in;
  logic [W-1:0]  data_out;
  logic          empty;
  logic          full;
  logic          almost_full;
  logic          almost_empty;
  logic [3:0]    count;
  logic          overflow;
  logic          underflow;

  int n_vec;
  int n_fail;

  typedef struct {
    logic         cs;
    logic         wr;
    logic         rd;
    logic [W-1:0] din;
    int           cnt;
    logic         ov;
    logic         un;
    logic [W-1:0] dout;
  } vec_t;

  vec_t vq[$];
  logic [W-1:0] exp_q[$];

  sync_fifo_param #(
    .WIDTH(W), .DEPTH(D), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)
  ) dut (
    .clk(clk), .rst(rst), .cs(cs), .wr_en(wr_en), .rd_en(rd_en),
    .data_in(data_in), .data_out(data_out), .empty(empty), .full(full),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic drive(input logic c, input logic w, input logic r, input logic [W-1:0] d);
    cs = c; wr_en = w; rd_en = r; data_in = d;
  endtask

  task automatic step(input logic c, input logic w, input logic r, input logic [W-1:0] d);
    drive(c, w, r, d);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Flags are re-derived from the expected occupancy with the bench thresholds.
  task automatic chk_state(input string tag, input int cnt, input logic ov, input logic un);
    chk({tag, ".count"},        32'(count),        32'(cnt));
    chk({tag, ".empty"},        32'(empty),        32'(cnt == 0));
    chk({tag, ".full"},         32'(full),         32'(cnt == D));
    chk({tag, ".almost_full"},  32'(almost_full),  32'(cnt >= AF));
    chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(cnt <= AE));
    chk({tag, ".overflow"},     32'(overflow),     32'(ov));
    chk({tag, ".underflow"},    32'(underflow),    32'(un));
  endtask

  function automatic vec_t mk(input logic c, input logic w, input logic r, input logic [W-1:0] d,
                              input int cnt, input logic ov, input logic un, input logic [W-1:0] q);
    vec_t v;
    v.cs = c; v.wr = w; v.rd = r; v.din = d; v.cnt = cnt; v.ov = ov; v.un = un; v.dout = q;
    return v;
  endfunction

  initial begin
    n_vec  = 0;
    n_fail = 0;
    drive(1'b0, 1'b0, 1'b0, '0);
    rst = 1'b1;

    // Fill / drain / boundary table (data_out expectations are standard mode).
    for (int k = 1; k <= 8; k++)
      vq.push_back(mk(1, 1, 0, W'(k), k, 0, 0, 16'h0000));
    vq.push_back(mk(1, 1, 0, 16'hDEAD, 8, 1, 0, 16'h0000));   // overflow
    vq.push_back(mk(1, 0, 0, 16'h0000, 8, 0, 0, 16'h0000));   // pulse ends
    vq.push_back(mk(1, 1, 1, 16'hBEEF, 7, 1, 0, 16'h0001));   // full: read only
    for (int k = 2; k <= 8; k++)
      vq.push_back(mk(1, 0, 1, 16'h0000, 8 - k, 0, 0, W'(k)));
    vq.push_back(mk(1, 1, 1, 16'h0055, 1, 0, 1, 16'h0008));   // empty: write only
    vq.push_back(mk(1, 0, 1, 16'h0000, 0, 0, 0, 16'h0055));
    vq.push_back(mk(1, 0, 1, 16'h0000, 0, 0, 1, 16'h0055));   // dropped read holds
    vq.push_back(mk(0, 1, 1, 16'h1234, 0, 0, 0, 16'h0055));   // cs low
    vq.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 16'h0055));

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // reset state
    chk_state("reset", 0, 0, 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("reset.data_out", 32'(data_out), 32'h0);
`endif

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].cs, vq[i].wr, vq[i].rd, vq[i].din);
      chk_state($sformatf("vec%0d", i), vq[i].cnt, vq[i].ov, vq[i].un);
`ifndef SYNC_FIFO_FWFT_EN
      chk($sformatf("vec%0d.data_out", i), 32'(data_out), 32'(vq[i].dout));
`endif
    end

    // Wrap: keep one word resident and stream 3*DEPTH read+write cycles.
    step(1, 1, 0, 16'h0100);
    exp_q.push_back(16'h0100);
    chk_state("wrap.prime", 1, 0, 0);
    for (int i = 0; i < 3 * D; i++) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
`ifdef SYNC_FIFO_FWFT_EN
      chk($sformatf("wrap%0d.head", i), 32'(data_out), 32'(e));
`endif
      exp_q.push_back(W'(16'h0101 + i));
      step(1, 1, 1, W'(16'h0101 + i));
`ifndef SYNC_FIFO_FWFT_EN
      chk($sformatf("wrap%0d.data_out", i), 32'(data_out), 32'(e));
`endif
      chk($sformatf("wrap%0d.count", i), 32'(count), 32'd1);
    end
    step(0, 1, 1, 16'hFFFF);
    chk_state("wrap.cs_low", 1, 0, 0);
`ifdef SYNC_FIFO_FWFT_EN
    chk("wrap.cs_low.head", 32'(data_out), 32'(exp_q[0]));
`else
    chk("wrap.cs_low.data_out", 32'(data_out), 32'h0117);
`endif

    // Asynchronous reset mid-stream with count = 5, no clock edge.
    for (int k = 0; k < 4; k++) step(1, 1, 0, W'(16'h0200 + k));
    chk("pre_rst.count", 32'(count), 32'd5);
    drive(1'b0, 1'b0, 1'b0, '0);
    #2 rst = 1'b1;
    #1;
    chk_state("async_rst", 0, 0, 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("async_rst.data_out", 32'(data_out), 32'h0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    step(1, 0, 1, 16'h0000);
    chk_state("post_rst.read", 0, 0, 1);
    step(1, 0, 0, 16'h0000);
    chk_state("post_rst.idle", 0, 0, 0);

    // Single word into empty FIFO, then pop it.
    step(1, 1, 0, 16'h00A5);
    chk_state("a5.write", 1, 0, 0);
`ifdef SYNC_FIFO_FWFT_EN
    chk("a5.fwft_head", 32'(data_out), 32'h00A5);
`endif
    step(1, 0, 1, 16'h0000);
    chk_state("a5.read", 0, 0, 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("a5.data_out", 32'(data_out), 32'h00A5);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
